// File: rtl/text_console_pkg.sv
// Shared geometry, control codes and FSM state type for the text console writer.
package text_console_pkg;

    localparam int COLS   = 64;
    localparam int ROWS   = 16;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 4;
    localparam int ADDR_W = COL_W + ROW_W;

    localparam logic [7:0] BLANK_CODE = 8'h00;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] FIRST_PRINTABLE = 8'h20;

    localparam logic [COL_W-1:0]  MAX_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  MAX_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    // The bottom row starts here; scroll copy covers every cell below it.
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(COLS);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_COPY,
        SCROLL_CLEAR
    } state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// 1024x8 character buffer: one write port, two synchronous read-first read ports
// (display and scroll). Only the display output register is reset.
module text_buffer_ram
    import text_console_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    input  logic [ADDR_W-1:0] scroll_addr,
    output logic [7:0]        scroll_data
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        scroll_data <= mem[scroll_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= 8'h00;
        end else begin
            disp_data <= mem[disp_addr];
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: byte stream in, cursor handling, wrap, scroll and clear.
// Optional cursor blink overlay on the display port when CURSOR_BLINK_EN is defined.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter logic [7:0]  CURSOR_CODE = 8'h2B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    input  logic [ADDR_W-1:0] sel,
    output logic [7:0]        data,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  cnt, cnt_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [COL_W-1:0]   col, col_n;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [7:0]         wdata;
    logic [7:0]         disp_rd_p1;
    logic [7:0]         scroll_rd_p1;
    logic               accept;

    assign char_ready = (state == IDLE) && !rst;
    assign accept     = char_valid && char_ready;
    assign busy       = (state != IDLE);
    assign cursor_row = row;
    assign cursor_col = col;

    text_buffer_ram u_ram (
        .clk         (clk),
        .rst         (rst),
        .we          (we && !rst),
        .waddr       (waddr),
        .wdata       (wdata),
        .disp_addr   (sel),
        .disp_data   (disp_rd_p1),
        .scroll_addr (cnt + ROW_STRIDE),
        .scroll_data (scroll_rd_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
            col   <= col_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        col_n   = col;
        we      = 1'b0;
        waddr   = cnt;
        wdata   = BLANK_CODE;

        case (state)
            CLEAR: begin
                we    = 1'b1;
                cnt_n = cnt + 10'd1;
                if (cnt == LAST_ADDR) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    row_n   = '0;
                    col_n   = '0;
                end
            end

            // cnt reads cell cnt+64; the value lands one row up on the next cycle.
            SCROLL_COPY: begin
                we    = (cnt != '0);
                waddr = cnt - 10'd1;
                wdata = scroll_rd_p1;
                cnt_n = cnt + 10'd1;
                if (cnt == LAST_ROW_BASE) begin
                    state_n = SCROLL_CLEAR;
                    cnt_n   = LAST_ROW_BASE;
                end
            end

            SCROLL_CLEAR: begin
                we    = 1'b1;
                cnt_n = cnt + 10'd1;
                if (cnt == LAST_ADDR) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end

            IDLE: begin
                if (accept) begin
                    if (char_data >= FIRST_PRINTABLE) begin
                        we    = 1'b1;
                        waddr = cell_addr(row, col);
                        wdata = char_data;
                        if (col == MAX_COL) begin
                            col_n = '0;
                            if (row == MAX_ROW) begin
                                state_n = SCROLL_COPY;
                                cnt_n   = '0;
                            end else begin
                                row_n = row + 4'd1;
                            end
                        end else begin
                            col_n = col + 6'd1;
                        end
                    end else begin
                        case (char_data)
                            CC_LF: begin
                                col_n = '0;
                                if (row == MAX_ROW) begin
                                    state_n = SCROLL_COPY;
                                    cnt_n   = '0;
                                end else begin
                                    row_n = row + 4'd1;
                                end
                            end
                            CC_CR: col_n = '0;
                            CC_BS: begin
                                if (col != '0) begin
                                    col_n = col - 6'd1;
                                    we    = 1'b1;
                                    waddr = cell_addr(row, col - 6'd1);
                                end else if (row != '0) begin
                                    row_n = row - 4'd1;
                                    col_n = MAX_COL;
                                    we    = 1'b1;
                                    waddr = cell_addr(row - 4'd1, MAX_COL);
                                end
                            end
                            CC_FF: begin
                                state_n = CLEAR;
                                cnt_n   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               subst_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            subst_p1    <= 1'b0;
        end else begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            // Decided alongside the RAM read so the overlay keeps 1-cycle latency.
            subst_p1 <= blink_phase && (sel == cell_addr(row, col)) && (state == IDLE);
        end
    end

    assign data = subst_p1 ? CURSOR_CODE : disp_rd_p1;
`else
    // Blink parameters have no effect in this build.
    logic blink_unused;
    assign blink_unused = (BLINK_DIV == 0) ^ (CURSOR_CODE == 8'h00);
    assign data = disp_rd_p1;
`endif

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer end of the character-buffer interface used by the VGA text display.
- Accepts a byte stream of character codes over a valid/ready handshake and keeps a cursor.
- Writes characters into a 64-column x 16-row buffer, handling control codes, line wrap and scrolling.
- Exposes the display read port: the display drives `sel` and receives the character code on `data`.

Parameters:
- COLS, 64, characters per row (power of 2; column index width 6).
- ROWS, 16, rows (power of 2; row index width 4).
- BLANK_CODE, 8'h00, code written for cleared cells.
- BLINK_DIV, 25_000_000, clk cycles per cursor blink half-period (used only with CURSOR_BLINK_EN).
- CURSOR_CODE, 8'h2B, glyph substituted at the cursor during the blink-on phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  char_data is valid.
- char_ready  out  1  block can accept a byte this cycle.
- char_data  in  8  character or control code.
- sel  in  10  display read address, {row[3:0], col[5:0]}.
- data  out  8  character code at sel, registered (1-cycle latency).
- cursor_row  out  4  current cursor row.
- cursor_col  out  6  current cursor column.
- busy  out  1  high in CLEAR, SCROLL_COPY or SCROLL_CLEAR.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cursor_row=0, cursor_col=0, char_ready=0, busy=1, data=8'h00. The state machine enters CLEAR.
- Handshake: a byte transfers when char_valid && char_ready. char_ready is 1 only in IDLE. Every accepted byte is consumed in the acceptance cycle.
- States: IDLE, CLEAR, SCROLL_COPY, SCROLL_CLEAR.
- CLEAR:
  - Writes BLANK_CODE to addresses 0..1023, one per cycle (1024 cycles).
  - Then sets the cursor to (0,0) and goes to IDLE.
- Printable byte (code >= 8'h20) in IDLE:
  - Written at {row,col} in the same cycle; col increments.
  - At col 63: col=0 and row increments.
  - At (15,63): the write happens, cursor goes to (15,0) and the FSM goes to SCROLL_COPY.
- 8'h0A (LF): col=0. If row<15, row increments; if row=15, go to SCROLL_COPY with cursor at (15,0).
- 8'h0D (CR): col=0, row unchanged.
- 8'h08 (BS):
  - Cursor moves back one cell, wrapping to (row-1,63) from col 0.
  - BLANK_CODE is written at the new position.
  - At (0,0): no move, no write.
- 8'h0C (FF): go to CLEAR.
- Other codes below 8'h20: accepted and ignored.
- SCROLL_COPY:
  - Pipelined internal read. Cycle k reads address 64+k; cycle k+1 writes that value to address k.
  - Covers k=0..959; lasts 961 cycles.
- SCROLL_CLEAR: writes BLANK_CODE to 960..1023 (64 cycles), then goes to IDLE.
- Display port:
  - data <= mem[sel] on every clk edge, in every state.
  - A write and a display read of the same address in one cycle returns the old value (read-first).
- Reset mid-CLEAR or mid-scroll aborts the operation immediately and restarts CLEAR from address 0.
- Addresses are 10 bits wide; the address counter wraps naturally and never exceeds 1023.

Optional Feature:
- CURSOR_BLINK_EN defined:
  - A counter toggles blink_phase every BLINK_DIV cycles; counter and phase reset to 0.
  - If blink_phase=1, the registered sel equals the cursor address, and the state is IDLE, then data=CURSOR_CODE instead of the RAM value.
  - The substitution decision is registered, so latency stays 1.
- CURSOR_BLINK_EN undefined: no counter; data is always the RAM value.

Decomposition:
- Package text_console_pkg holds:
  - COLS, ROWS, BLANK_CODE;
  - control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D;
  - state typedef {IDLE, CLEAR, SCROLL_COPY, SCROLL_CLEAR}.
- One sub-module, text_buffer_ram: 1024x8, one write port and two synchronous read-first read ports (display, scroll).

Test Plan:
- Reset, then wait: busy=1 for exactly 1024 cycles, then char_ready=1 and the cursor is (0,0). A read of sel=10'h3FF returns 8'h00.
- Send 8'h41, 8'h42: sel=0 returns 8'h41 and sel=1 returns 8'h42, one cycle after sel is applied; cursor_col=2.
- Send 64 printable bytes on row 0: cursor becomes (1,0). Then send BS: cursor (0,63) and sel=63 returns BLANK_CODE. A BS at (0,0) leaves the cursor unchanged.
- Fill row 1 with 8'h31 and put the cursor at (15,5); send LF:
  - busy stays high for 961+64 cycles;
  - afterwards sel=0 returns 8'h31, sel=960..1023 return BLANK_CODE, cursor is (15,0).
- Assert char_valid during SCROLL_COPY: char_ready stays 0 and no byte is lost; the byte is accepted on the first IDLE cycle.
- Assert rst mid-scroll: the next cycle is CLEAR at address 0, cursor (0,0), char_ready=0.
